// File: rtl/b16_bus_pkg.sv
// Shared types for the b16 memory bus arbiter: bus owner encoding and byte-strobe constants.
package b16_bus_pkg;

   typedef enum logic {
      OWN_CPU  = 1'b0,
      OWN_HOST = 1'b1
   } owner_t;

   localparam logic [1:0] WR_NONE = 2'b00;
   localparam logic [1:0] WR_HI   = 2'b10;
   localparam logic [1:0] WR_LO   = 2'b01;
   localparam logic [1:0] WR_BOTH = 2'b11;

endpackage

// File: rtl/b16_bus_mux.sv
// Owner-selected address/data/strobe mux in front of the single-port memory.
module b16_bus_mux
   import b16_bus_pkg::*;
#(
   parameter int L = 16
) (
   input  owner_t         owner,
   input  logic           cpu_run,
   input  logic [L-1:0]   cpu_addr,
   input  logic           cpu_rd,
   input  logic [1:0]     cpu_wr,
   input  logic [L-1:0]   cpu_dout,
   input  logic           host_gnt,
   input  logic [1:0]     host_we,
   input  logic [L-1:0]   host_addr,
   input  logic [L-1:0]   host_wdata,
   output logic [L-1:0]   mem_addr,
   output logic           mem_rd,
   output logic [1:0]     mem_wr,
   output logic [L-1:0]   mem_wdata
);

   // The cpu keeps driving its strobes while halted, so they only pass when it actually runs.
   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_dout;
      mem_rd    = cpu_rd & cpu_run;
      mem_wr    = cpu_run ? cpu_wr : WR_NONE;
      if (owner == OWN_HOST) begin
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
         mem_rd    = host_gnt & (host_we == WR_NONE);
         mem_wr    = host_gnt ? host_we : WR_NONE;
      end
   end

endmodule

// File: rtl/b16_bus_arbiter.sv
// Arbitrates the b16 program/data memory between the cpu and a host/DMA port,
// bounding host bursts and reserving cpu slots between them.
module b16_bus_arbiter
   import b16_bus_pkg::*;
#(
   parameter int L          = 16,
   parameter int HOST_BURST = 4,
   parameter int CPU_SLOTS  = 2
) (
   input  logic           clk,
   input  logic           nreset,
   input  logic           drun,
   output logic           cpu_run,
   input  logic [L-1:0]   cpu_addr,
   input  logic           cpu_rd,
   input  logic [1:0]     cpu_wr,
   input  logic [L-1:0]   cpu_dout,
   output logic [L-1:0]   cpu_din,
   input  logic           host_req,
   input  logic [1:0]     host_we,
   input  logic [L-1:0]   host_addr,
   input  logic [L-1:0]   host_wdata,
   output logic           host_gnt,
   output logic [L-1:0]   host_rdata,
   output logic           host_rvalid,
   output logic [L-1:0]   mem_addr,
   output logic           mem_rd,
   output logic [1:0]     mem_wr,
   output logic [L-1:0]   mem_wdata,
   input  logic [L-1:0]   mem_rdata
);

   localparam int CW = $clog2(CPU_SLOTS + 1);
   localparam int BW = (HOST_BURST > 1) ? $clog2(HOST_BURST) : 1;
   localparam logic [CW-1:0] CREDIT_FULL = CW'(CPU_SLOTS);
   localparam logic [BW-1:0] BURST_LAST  = BW'(HOST_BURST - 1);

   owner_t         owner_q, owner_d;
   logic [CW-1:0]  credit_q, credit_d;
   logic [BW-1:0]  burst_q, burst_d;
   logic           rvalid_q, rvalid_d;
   logic [L-1:0]   rdata_q, rdata_d;

   // Reset gates both requesters so nothing reaches the memory while nreset is low.
   assign cpu_run     = nreset & drun & (owner_q == OWN_CPU);
   assign host_gnt    = nreset & host_req & (owner_q == OWN_HOST);
   assign cpu_din     = mem_rdata;
   assign host_rdata  = rdata_q;
   assign host_rvalid = rvalid_q;

   b16_bus_mux #(.L(L)) u_mux (
      .owner      (owner_q),
      .cpu_run    (cpu_run),
      .cpu_addr   (cpu_addr),
      .cpu_rd     (cpu_rd),
      .cpu_wr     (cpu_wr),
      .cpu_dout   (cpu_dout),
      .host_gnt   (host_gnt),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_wdata  (mem_wdata)
   );

   always_comb begin
      owner_d  = owner_q;
      credit_d = credit_q;
      burst_d  = burst_q;
      rvalid_d = host_gnt & (host_we == WR_NONE);
      rdata_d  = rvalid_d ? mem_rdata : rdata_q;
      case (owner_q)
         OWN_CPU: begin
            burst_d = '0;
            if (cpu_run && (credit_q != '0))
               credit_d = credit_q - 1'b1;
            if (host_req && ((credit_q == '0) || !drun))
               owner_d = OWN_HOST;
         end
         OWN_HOST: begin
            // Burst length is only bounded while the debugger lets the cpu run.
            credit_d = '0;
            if (!host_req) begin
               owner_d  = OWN_CPU;
               burst_d  = '0;
               credit_d = drun ? CREDIT_FULL : '0;
            end else if (!drun) begin
               burst_d = '0;
            end else if (burst_q == BURST_LAST) begin
               owner_d  = OWN_CPU;
               burst_d  = '0;
               credit_d = CREDIT_FULL;
            end else begin
               burst_d = burst_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         owner_q  <= OWN_CPU;
         credit_q <= '0;
         burst_q  <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         owner_q  <= owner_d;
         credit_q <= credit_d;
         burst_q  <= burst_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_b16_bus_arbiter.sv
// Directed bench for b16_bus_arbiter with a small async-read memory model on the bus side.
module tb_b16_bus_arbiter;

   logic        clk;
   logic        nreset;
   logic        drun;
   logic        cpu_run;
   logic [15:0] cpu_addr;
   logic        cpu_rd;
   logic [1:0]  cpu_wr;
   logic [15:0] cpu_dout;
   logic [15:0] cpu_din;
   logic        host_req;
   logic [1:0]  host_we;
   logic [15:0] host_addr;
   logic [15:0] host_wdata;
   logic        host_gnt;
   logic [15:0] host_rdata;
   logic        host_rvalid;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [1:0]  mem_wr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   logic [15:0] mem [0:511];

   int vectors;
   int miscompares;

   b16_bus_arbiter #(.L(16), .HOST_BURST(4), .CPU_SLOTS(2)) dut (
      .clk         (clk),
      .nreset      (nreset),
      .drun        (drun),
      .cpu_run     (cpu_run),
      .cpu_addr    (cpu_addr),
      .cpu_rd      (cpu_rd),
      .cpu_wr      (cpu_wr),
      .cpu_dout    (cpu_dout),
      .cpu_din     (cpu_din),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_gnt    (host_gnt),
      .host_rdata  (host_rdata),
      .host_rvalid (host_rvalid),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_wr      (mem_wr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory is preloaded while reset is held and byte-written otherwise.
   assign mem_rdata = mem[mem_addr[9:1]];
   always @(posedge clk) begin
      if (!nreset) begin
         mem[9'h080] <= 16'hBEEF;
         mem[9'h100] <= 16'h0000;
      end else begin
         if (mem_wr[0]) mem[mem_addr[9:1]][7:0]  <= mem_wdata[7:0];
         if (mem_wr[1]) mem[mem_addr[9:1]][15:8] <= mem_wdata[15:8];
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      nreset      = 1'b0;
      drun        = 1'b1;
      cpu_addr    = 16'h0040;
      cpu_rd      = 1'b1;
      cpu_wr      = 2'b11;
      cpu_dout    = 16'h5555;
      host_req    = 1'b1;
      host_we     = 2'b00;
      host_addr   = 16'h0100;
      host_wdata  = 16'h0000;

      $display("[TB] reset with cpu_wr=11 and host_req=1");
      next_cycle();
      #1;
      check_output("rst_mem_wr", mem_wr, 2'b00);
      check_output("rst_mem_rd", mem_rd, 1'b0);
      check_output("rst_cpu_run", cpu_run, 1'b0);
      check_output("rst_host_gnt", host_gnt, 1'b0);
      next_cycle();
      nreset   = 1'b1;
      host_req = 1'b0;
      cpu_wr   = 2'b00;
      #1;
      check_output("rel_cpu_run", cpu_run, 1'b1);
      check_output("rel_rvalid", host_rvalid, 1'b0);
      check_output("rel_rdata", host_rdata, 16'h0000);
      check_output("rel_host_gnt", host_gnt, 1'b0);

      $display("[TB] single host read of 0x0100");
      next_cycle();
      host_req  = 1'b1;
      host_addr = 16'h0100;
      host_we   = 2'b00;
      #1;
      check_output("rd_c0_gnt", host_gnt, 1'b0);
      check_output("rd_c0_run", cpu_run, 1'b1);
      next_cycle();
      #1;
      check_output("rd_c1_gnt", host_gnt, 1'b1);
      check_output("rd_c1_addr", mem_addr, 16'h0100);
      check_output("rd_c1_rd", mem_rd, 1'b1);
      check_output("rd_c1_wr", mem_wr, 2'b00);
      check_output("rd_c1_run", cpu_run, 1'b0);
      check_output("rd_c1_din", cpu_din, 16'hBEEF);
      next_cycle();
      host_req = 1'b0;
      #1;
      check_output("rd_c2_rvalid", host_rvalid, 1'b1);
      check_output("rd_c2_rdata", host_rdata, 16'hBEEF);
      check_output("rd_c2_gnt", host_gnt, 1'b0);
      next_cycle();
      #1;
      check_output("rd_c3_rvalid", host_rvalid, 1'b0);
      check_output("rd_c3_rdata", host_rdata, 16'hBEEF);
      check_output("rd_c3_run", cpu_run, 1'b1);
      next_cycle();
      next_cycle();

      $display("[TB] held host request, 4 grants then 3 cpu cycles");
      for (int d = 0; d < 20; d++) begin
         next_cycle();
         host_req  = 1'b1;
         host_addr = 16'h0100;
         #1;
         check_output($sformatf("burst_gnt_%0d", d), host_gnt, ((d % 7) >= 1 && (d % 7) <= 4) ? 1'b1 : 1'b0);
         check_output($sformatf("burst_run_%0d", d), cpu_run, ((d % 7) >= 1 && (d % 7) <= 4) ? 1'b0 : 1'b1);
      end

      $display("[TB] halted cpu, eight host byte writes");
      next_cycle();
      drun       = 1'b0;
      host_req   = 1'b1;
      host_we    = 2'b01;
      host_addr  = 16'h0200;
      host_wdata = 16'h1234;
      cpu_wr     = 2'b11;
      cpu_addr   = 16'h0200;
      #1;
      check_output("wr_e0_mem_wr", mem_wr, 2'b00);
      check_output("wr_e0_gnt", host_gnt, 1'b0);
      check_output("wr_e0_run", cpu_run, 1'b0);
      for (int e = 1; e <= 8; e++) begin
         next_cycle();
         #1;
         check_output($sformatf("wr_gnt_%0d", e), host_gnt, 1'b1);
         check_output($sformatf("wr_mem_wr_%0d", e), mem_wr, 2'b01);
         check_output($sformatf("wr_addr_%0d", e), mem_addr, 16'h0200);
         check_output($sformatf("wr_wdata_%0d", e), mem_wdata, 16'h1234);
         check_output($sformatf("wr_rd_%0d", e), mem_rd, 1'b0);
      end
      next_cycle();
      host_req = 1'b0;
      cpu_wr   = 2'b00;
      #1;
      check_output("wr_e9_gnt", host_gnt, 1'b0);
      check_output("wr_e9_rvalid", host_rvalid, 1'b0);
      check_output("wr_mem_word", mem[9'h100], 16'h0034);

      $display("[TB] drun drops mid-burst, then rises again");
      next_cycle();
      drun      = 1'b1;
      host_req  = 1'b1;
      host_we   = 2'b00;
      host_addr = 16'h0100;
      #1;
      check_output("dr_f0_gnt", host_gnt, 1'b0);
      next_cycle();
      #1;
      check_output("dr_f1_gnt", host_gnt, 1'b1);
      next_cycle();
      drun = 1'b0;
      #1;
      check_output("dr_f2_gnt", host_gnt, 1'b1);
      for (int f = 3; f <= 8; f++) begin
         next_cycle();
         #1;
         check_output($sformatf("dr_unb_gnt_%0d", f), host_gnt, 1'b1);
      end
      next_cycle();
      drun = 1'b1;
      #1;
      check_output("dr_f9_gnt", host_gnt, 1'b1);
      for (int f = 10; f <= 12; f++) begin
         next_cycle();
         #1;
         check_output($sformatf("dr_lim_gnt_%0d", f), host_gnt, 1'b1);
      end
      next_cycle();
      #1;
      check_output("dr_f13_gnt", host_gnt, 1'b0);
      check_output("dr_f13_run", cpu_run, 1'b1);
      next_cycle();
      host_req = 1'b0;
      next_cycle();

      $display("[TB] reset right after a read grant");
      next_cycle();
      host_req  = 1'b1;
      host_addr = 16'h0100;
      host_we   = 2'b00;
      #1;
      check_output("rr_g0_gnt", host_gnt, 1'b0);
      next_cycle();
      #1;
      check_output("rr_g1_gnt", host_gnt, 1'b1);
      check_output("rr_g1_rd", mem_rd, 1'b1);
      next_cycle();
      nreset = 1'b0;
      cpu_wr = 2'b11;
      #1;
      check_output("rr_g2_gnt", host_gnt, 1'b0);
      check_output("rr_g2_mem_wr", mem_wr, 2'b00);
      check_output("rr_g2_mem_rd", mem_rd, 1'b0);
      check_output("rr_g2_run", cpu_run, 1'b0);
      next_cycle();
      nreset   = 1'b1;
      host_req = 1'b0;
      cpu_wr   = 2'b00;
      #1;
      check_output("rr_g3_rvalid", host_rvalid, 1'b0);
      check_output("rr_g3_rdata", host_rdata, 16'h0000);
      check_output("rr_g3_run", cpu_run, 1'b1);
      check_output("rr_g3_gnt", host_gnt, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
